// File: rtl/div_seq.sv
// Iterative 32-bit signed non-restoring divider: quotient to lo, remainder to hi.
// One add/subtract step per cycle through a shared 32-bit adder, start/busy/done handshake.

module adder_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};
endmodule

module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t      r_state;
  logic [32:0] r_a;
  logic [31:0] r_q;
  logic [31:0] r_m;
  logic        r_qNeg;
  logic        r_mNeg;
  logic [4:0]  r_count;
  logic        r_busy;
  logic        r_done;
  logic        r_dbz;
  logic [31:0] r_lo;
  logic [31:0] r_hi;

  logic [32:0] w_shift;
  logic        w_sub;
  logic [31:0] w_addA;
  logic [31:0] w_addB;
  logic        w_cin;
  logic [31:0] w_sum;
  logic        w_cout;
  logic [32:0] w_newA;
  logic [31:0] w_rem;
  logic [31:0] w_quoOut;
  logic [31:0] w_remOut;
  logic [31:0] w_qMag;
  logic [31:0] w_mMag;

  // The adder serves the ITER add/subtract steps and the FIX remainder restore.
  assign w_shift = {r_a[31:0], r_q[31]};
  assign w_sub   = ~r_a[32];
  assign w_addA  = (r_state == FIX) ? r_a[31:0] : w_shift[31:0];
  assign w_addB  = ((r_state == ITER) && w_sub) ? ~r_m : r_m;
  assign w_cin   = (r_state == ITER) && w_sub;

  adder_32 u_adder (
    .i_a   (w_addA),
    .i_b   (w_addB),
    .i_cin (w_cin),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  // Bit 32 of the operand pair is the shifted sign and the (possibly inverted) zero extension of M.
  assign w_newA   = {w_shift[32] ^ w_sub ^ w_cout, w_sum};
  assign w_rem    = r_a[32] ? w_sum : r_a[31:0];
  assign w_quoOut = (r_qNeg ^ r_mNeg) ? (~r_q + 32'd1) : r_q;
  assign w_remOut = r_qNeg ? (~w_rem + 32'd1) : w_rem;
  assign w_qMag   = r_q[31] ? (~r_q + 32'd1) : r_q;
  assign w_mMag   = r_m[31] ? (~r_m + 32'd1) : r_m;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_qNeg  <= 1'b0;
      r_mNeg  <= 1'b0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_q     <= dividend;
            r_m     <= divisor;
            r_qNeg  <= dividend[31];
            r_mNeg  <= divisor[31];
            r_dbz   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= PREP;
          end
        end
        PREP: begin
          if (r_m == 32'd0) begin
            r_hi    <= r_q;
            r_lo    <= '1;
            r_dbz   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_q     <= w_qMag;
            r_m     <= w_mMag;
            r_a     <= '0;
            r_count <= '0;
            r_state <= ITER;
          end
        end
        ITER: begin
          r_a     <= w_newA;
          r_q     <= {r_q[30:0], ~w_newA[32]};
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) r_state <= FIX;
        end
        FIX: begin
          r_lo    <= w_quoOut;
          r_hi    <= w_remOut;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dbz  = r_dbz;
  assign lo   = r_lo;
  assign hi   = r_hi;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random operands
// compared against a plain signed-arithmetic reference.

module tb_div_seq;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] lo;
  logic [31:0] hi;

  int compareCount = 0;
  int mismatchCount = 0;

  always #5 clock = ~clock;

  div_seq #(.WIDTH(32)) dut (
    .clock   (clock),
    .clear   (clear),
    .start   (start),
    .dividend(dividend),
    .divisor (divisor),
    .busy    (busy),
    .done    (done),
    .dbz     (dbz),
    .lo      (lo),
    .hi      (hi)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Truncating signed division; 64-bit intermediates make the 0x80000000/-1 case wrap naturally.
  function automatic void refDiv(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa;
    longint sb;
    longint qq;
    longint rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      q  = qq[31:0];
      r  = rr[31:0];
      z  = 1'b0;
    end
  endfunction

  // injectAt >= 0 pulses start with other operands that many cycles after acceptance.
  task automatic applyStimulus(input logic [31:0] dvd, input logic [31:0] dvs, input int injectAt,
                               input logic [31:0] injDvd, input logic [31:0] injDvs);
    logic [31:0] expLo;
    logic [31:0] expHi;
    logic        expZ;
    int          cycles;
    int          busyCycles;
    int          expLat;
    bit          seenDone;
    refDiv(dvd, dvs, expLo, expHi, expZ);
    expLat = expZ ? 2 : 35;
    @(negedge clock);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    cycles     = 0;
    busyCycles = busy ? 1 : 0;
    seenDone   = 1'b0;
    while (!seenDone && cycles < 100) begin
      if (cycles == injectAt) begin
        start    = 1'b1;
        dividend = injDvd;
        divisor  = injDvs;
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      cycles++;
      if (done) seenDone = 1'b1;
      else if (busy) busyCycles++;
    end
    checkOutput("latency", cycles, expLat);
    checkOutput("busyCycles", busyCycles, expLat);
    checkOutput("busyAtDone", {31'd0, busy}, 32'd0);
    checkOutput("lo", lo, expLo);
    checkOutput("hi", hi, expHi);
    checkOutput("dbz", {31'd0, dbz}, {31'd0, expZ});
    @(posedge clock);
    #1;
    checkOutput("donePulse", {31'd0, done}, 32'd0);
    checkOutput("loHold", lo, expLo);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    bit          doneDuringReset;

    #1;
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetDone", {31'd0, done}, 32'd0);
    checkOutput("resetDbz", {31'd0, dbz}, 32'd0);
    checkOutput("resetLo", lo, 32'd0);
    checkOutput("resetHi", hi, 32'd0);
    repeat (2) @(negedge clock);
    clear = 1'b1;

    applyStimulus(32'd100, 32'd7, -1, 32'd0, 32'd0);
    applyStimulus(-32'sd100, 32'd7, -1, 32'd0, 32'd0);
    applyStimulus(32'd100, -32'sd7, -1, 32'd0, 32'd0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, -1, 32'd0, 32'd0);
    applyStimulus(32'hFFFF_FFFF, 32'h8000_0000, -1, 32'd0, 32'd0);
    applyStimulus(32'd1234, 32'd0, -1, 32'd0, 32'd0);
    applyStimulus(32'd9, 32'd3, -1, 32'd0, 32'd0);
    applyStimulus(32'd100, 32'd7, 9, 32'd50, 32'd5);
    applyStimulus(32'h8000_0000, 32'h8000_0000, -1, 32'd0, 32'd0);
    applyStimulus(32'h7FFF_FFFF, 32'd1, -1, 32'd0, 32'd0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'h8000_0000;
        3:       b = $urandom_range(1, 20);
        4:       b = -$urandom_range(1, 1000);
        default: b = $urandom;
      endcase
      if (i % 8 == 0) a = 32'h8000_0000;
      applyStimulus(a, b, -1, 32'd0, 32'd0);
    end

    // Abandon a division mid-flight with clear.
    @(negedge clock);
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clock);
    #1;
    clear = 1'b0;
    #1;
    checkOutput("clearBusy", {31'd0, busy}, 32'd0);
    checkOutput("clearDone", {31'd0, done}, 32'd0);
    checkOutput("clearDbz", {31'd0, dbz}, 32'd0);
    checkOutput("clearLo", lo, 32'd0);
    checkOutput("clearHi", hi, 32'd0);
    doneDuringReset = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (done) doneDuringReset = 1'b1;
    end
    checkOutput("noDoneInReset", {31'd0, doneDuringReset}, 32'd0);
    @(negedge clock);
    clear = 1'b1;
    applyStimulus(32'd100, 32'd7, -1, 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
